// File: rtl/ndn_pkg.sv
// Shared PIT types: FSM states, table_entry layout, defaults and address helpers.
package ndn_pkg;

    localparam int unsigned DEF_TABLE_DEPTH = 16;
    localparam int unsigned DEF_REGION_SIZE = 1024;
    localparam int unsigned DEF_HOLD_CYCLES = 1026;
    localparam int unsigned HIT_BIT         = 62;
    localparam int unsigned ADDR_W          = 62;
    // Short busy window after a data miss, covering the FIB forward hand-off.
    localparam int unsigned DMISS_HOLD      = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HASH,
        S_LOOKUP,
        S_ISSUE,
        S_HOLD
    } pit_state_t;

    // table_entry: [63] reserved zero, [62] hit/alloc flag, [61:0] slot address.
    typedef struct packed {
        logic              rsvd;
        logic              hit;
        logic [ADDR_W-1:0] addr;
    } pit_entry_t;

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] base,
                                                     input int unsigned idx,
                                                     input int unsigned rsize);
        return base + ADDR_W'(idx) * ADDR_W'(rsize);
    endfunction

    function automatic pit_entry_t make_entry(input logic hit, input logic [ADDR_W-1:0] addr);
        logic [63:0] v;
        v             = '0;
        v[HIT_BIT]    = hit;
        v[ADDR_W-1:0] = addr;
        return pit_entry_t'(v);
    endfunction

endpackage

// File: rtl/pit_lookup_if.sv
// Name-byte stream in, lookup results and counters out.
interface pit_lookup_if;
    logic        name_valid;
    logic [7:0]  name_byte;
    logic        name_last;
    logic        name_type;
    logic        name_ready;
    logic [63:0] table_entry;
    logic        in_bit;
    logic        out_bit;
    logic [7:0]  drop_count;
    logic [7:0]  agg_count;

    modport master (
        output name_valid, name_byte, name_last, name_type,
        input  name_ready, table_entry, in_bit, out_bit, drop_count, agg_count
    );

    modport slave (
        input  name_valid, name_byte, name_last, name_type,
        output name_ready, table_entry, in_bit, out_bit, drop_count, agg_count
    );
endinterface

// File: rtl/name_hash.sv
// Rolling 16-bit name tag: rotate-left-by-one then XOR in each accepted byte.
module name_hash (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        first_i,
    input  logic [7:0]  data_i,
    output logic [15:0] tag_o
);
    logic [15:0] h_q;
    logic [15:0] seed;
    logic [15:0] h_d;

    // The first byte of a name restarts from the all-ones seed.
    always_comb begin
        seed = first_i ? 16'hFFFF : h_q;
        h_d  = {seed[14:0], seed[15]} ^ {8'h00, data_i};
    end

    // Fold each accepted byte into the running tag.
    always_ff @(posedge clk) begin
        if (reset)        h_q <= 16'hFFFF;
        else if (valid_i) h_q <= h_d;
    end

    assign tag_o = h_q;
endmodule

// File: rtl/pit_lookup.sv
// Pending Interest Table lookup: hash a name, match it against the slot tags,
// then allocate, aggregate, drop or consume an entry and report the slot address.
module pit_lookup
    import ndn_pkg::*;
#(
    parameter int unsigned       TABLE_DEPTH = DEF_TABLE_DEPTH,
    parameter int unsigned       REGION_SIZE = DEF_REGION_SIZE,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
    parameter int unsigned       HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    pit_lookup_if.slave  bus
);
    localparam int unsigned IW  = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1) + 1;

    pit_state_t             state_q;
    logic                   ready_q;
    logic                   type_q;
    pit_entry_t             entry_q;
    logic                   in_q;
    logic                   out_q;
    logic [7:0]             drop_q;
    logic [7:0]             agg_q;
    logic [HCW-1:0]         hold_q;
    logic [TABLE_DEPTH-1:0] valid_q;
    logic [15:0]            tag_q [TABLE_DEPTH];

    logic          accept;
    logic [15:0]   tag;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          full;
    logic [IW-1:0] free_idx;

    assign accept = bus.name_valid && ready_q;

    name_hash u_hash (
        .clk     (clk),
        .reset   (reset),
        .valid_i (accept),
        .first_i (state_q == S_IDLE),
        .data_i  (bus.name_byte),
        .tag_o   (tag)
    );

    // Single-cycle associative match; scanning downwards leaves the lowest index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        full     = 1'b1;
        free_idx = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                full     = 1'b0;
                free_idx = IW'(i);
            end
        end
    end

    // Control FSM with registered strobes, entry, counters and slot table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            type_q  <= 1'b0;
            entry_q <= '0;
            in_q    <= 1'b0;
            out_q   <= 1'b0;
            drop_q  <= '0;
            agg_q   <= '0;
            hold_q  <= '0;
            valid_q <= '0;
        end else begin
            in_q  <= 1'b0;
            out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        type_q <= bus.name_type;
                        if (bus.name_last) begin
                            state_q <= S_LOOKUP;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= S_HASH;
                        end
                    end
                end
                S_HASH: begin
                    if (accept && bus.name_last) begin
                        state_q <= S_LOOKUP;
                        ready_q <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (!type_q) begin
                        if (hit) begin
                            if (agg_q != 8'hFF) agg_q <= agg_q + 8'd1;
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end else if (full) begin
                            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            valid_q[free_idx] <= 1'b1;
                            tag_q[free_idx]   <= tag;
                            entry_q <= make_entry(1'b1, slot_addr(ADDR_BASE, 32'(free_idx), REGION_SIZE));
                            in_q    <= 1'b1;
                            hold_q  <= HCW'(HOLD_CYCLES - 1);
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        out_q   <= 1'b1;
                        state_q <= S_ISSUE;
                        if (hit) begin
                            // Data satisfies the pending interest, so the slot is freed.
                            valid_q[hit_idx] <= 1'b0;
                            entry_q <= make_entry(1'b1, slot_addr(ADDR_BASE, 32'(hit_idx), REGION_SIZE));
                            hold_q  <= HCW'(HOLD_CYCLES - 1);
                        end else begin
                            entry_q <= '0;
                            hold_q  <= HCW'(DMISS_HOLD - 1);
                        end
                    end
                end
                S_ISSUE: state_q <= S_HOLD;
                S_HOLD: begin
                    if (hold_q == '0) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.name_ready  = ready_q;
    assign bus.table_entry = entry_q;
    assign bus.in_bit      = in_q;
    assign bus.out_bit     = out_q;
    assign bus.drop_count  = drop_q;
    assign bus.agg_count   = agg_q;
endmodule

// File: tb/tb_pit_lookup.sv
// Bench for pit_lookup: directed vector table, reset corner sequences and
// randomized names checked against a slot-array reference model.
module tb_pit_lookup;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pit_lookup_if ifc ();
    pit_lookup dut (.clk(clk), .reset(reset), .bus(ifc));

    int n_chk  = 0;
    int n_fail = 0;
    int n_in   = 0;

    // Reference model state
    bit          mv [16];
    logic [15:0] mt [16];
    int          m_agg, m_drop;
    logic [63:0] m_entry;

    typedef struct {
        logic        typ;
        logic [63:0] b;
        int          n;
        logic        e_in;
        logic        e_out;
        logic [63:0] e_ent;
        logic [7:0]  e_agg;
        logic [7:0]  e_drop;
        int          e_hold;
        bit          junk;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mhash(input logic [63:0] b, input int n);
        int h = 16'hFFFF;
        for (int i = 0; i < n; i++)
            h = (((h << 1) | (h >> 15)) & 16'hFFFF) ^ int'((b >> (8 * i)) & 64'hFF);
        return h[15:0];
    endfunction

    function automatic logic [63:0] addr_of(input int j);
        return 64'h4000_0000_0000_0000 | 64'(j * 1024);
    endfunction

    task automatic mreset();
        for (int j = 0; j < 16; j++) mv[j] = 1'b0;
        m_agg = 0; m_drop = 0; m_entry = '0;
    endtask

    task automatic model_op(input logic typ, input logic [63:0] b, input int n,
                            output logic e_in, output logic e_out, output logic [63:0] e_ent,
                            output logic [7:0] e_agg, output logic [7:0] e_drop, output int e_hold);
        logic [15:0] t;
        int hit, fr;
        t = mhash(b, n); hit = -1; fr = -1;
        for (int j = 0; j < 16; j++) begin
            if (hit < 0 && mv[j] && mt[j] == t) hit = j;
            if (fr < 0 && !mv[j]) fr = j;
        end
        e_in = 1'b0; e_out = 1'b0; e_hold = 0;
        if (!typ) begin
            if (hit >= 0) m_agg++;
            else if (fr >= 0) begin
                mv[fr] = 1'b1; mt[fr] = t; m_entry = addr_of(fr); e_in = 1'b1; e_hold = 1026;
            end else m_drop++;
        end else begin
            e_out = 1'b1;
            if (hit >= 0) begin mv[hit] = 1'b0; m_entry = addr_of(hit); e_hold = 1026; end
            else begin m_entry = '0; e_hold = 3; end
        end
        e_ent  = m_entry;
        e_agg  = (m_agg > 255) ? 8'hFF : 8'(m_agg);
        e_drop = (m_drop > 255) ? 8'hFF : 8'(m_drop);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic last, input logic typ);
        int w = 0;
        while (ifc.name_ready !== 1'b1 && w < 3000) begin @(posedge clk); #1; w++; end
        if (w >= 3000) chk("ready_timeout", 64'(ifc.name_ready), 64'd1);
        ifc.name_valid = 1'b1; ifc.name_byte = b; ifc.name_last = last; ifc.name_type = typ;
        @(posedge clk); #1;
        ifc.name_valid = 1'b0; ifc.name_last = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic typ, input logic [63:0] b, input int n,
                          input logic e_in, input logic e_out, input logic [63:0] e_ent,
                          input logic [7:0] e_agg, input logic [7:0] e_drop,
                          input int e_hold, input bit junk);
        int k;
        for (int i = 0; i < n; i++) drive_byte(b[8*i +: 8], (i == n - 1), typ);
        chk({nm, ".lookup_quiet"}, {61'b0, ifc.in_bit, ifc.out_bit, ifc.name_ready}, 64'd0);
        @(posedge clk); #1;
        if (ifc.in_bit === 1'b1) n_in++;
        chk({nm, ".in_bit"},  64'(ifc.in_bit),  64'(e_in));
        chk({nm, ".out_bit"}, 64'(ifc.out_bit), 64'(e_out));
        chk({nm, ".entry"},   ifc.table_entry,  e_ent);
        chk({nm, ".agg"},     64'(ifc.agg_count),  64'(e_agg));
        chk({nm, ".drop"},    64'(ifc.drop_count), 64'(e_drop));
        if (e_hold == 0) begin
            chk({nm, ".ready_idle"}, 64'(ifc.name_ready), 64'd1);
        end else begin
            chk({nm, ".ready_issue"}, 64'(ifc.name_ready), 64'd0);
            k = 0;
            do begin
                @(posedge clk); #1; k++;
                if (k == 1) chk({nm, ".strobe_once"}, {62'b0, ifc.in_bit, ifc.out_bit}, 64'd0);
                if (junk && ifc.name_ready !== 1'b1) begin
                    ifc.name_valid = 1'b1; ifc.name_byte = 8'($urandom);
                    ifc.name_last = 1'($urandom); ifc.name_type = 1'($urandom);
                end
            end while (ifc.name_ready !== 1'b1 && k < 3000);
            ifc.name_valid = 1'b0; ifc.name_last = 1'b0;
            chk({nm, ".hold_len"}, 64'(k), 64'(e_hold + 1));
        end
    endtask

    task automatic model_run(input string nm, input logic typ, input logic [63:0] b,
                             input int n, input bit junk);
        logic ei, eo; logic [63:0] ee; logic [7:0] ea, ed; int eh;
        model_op(typ, b, n, ei, eo, ee, ea, ed, eh);
        run_op(nm, typ, b, n, ei, eo, ee, ea, ed, eh, junk);
    endtask

    task automatic do_reset();
        reset = 1'b1; ifc.name_valid = 1'b0; ifc.name_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready",   64'(ifc.name_ready), 64'd0);
        chk("rst.strobes", {62'b0, ifc.in_bit, ifc.out_bit}, 64'd0);
        chk("rst.entry",   ifc.table_entry, 64'd0);
        chk("rst.counts",  {48'b0, ifc.drop_count, ifc.agg_count}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst.ready_after", 64'(ifc.name_ready), 64'd1);
        mreset();
    endtask

    initial begin
        logic [63:0] b;
        int guard;
        ifc.name_valid = 1'b0; ifc.name_byte = '0; ifc.name_last = 1'b0; ifc.name_type = 1'b0;
        reset = 1'b1;

        tv[0] = '{1'b0, 64'h41,   1, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 8'd0, 8'd0, 1026, 1'b0};
        tv[1] = '{1'b0, 64'h41,   1, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 8'd1, 8'd0, 0,    1'b0};
        tv[2] = '{1'b0, 64'h42,   1, 1'b1, 1'b0, 64'h4000_0000_0000_0400, 8'd1, 8'd0, 1026, 1'b1};
        tv[3] = '{1'b1, 64'h41,   1, 1'b0, 1'b1, 64'h4000_0000_0000_0000, 8'd1, 8'd0, 1026, 1'b0};
        tv[4] = '{1'b1, 64'h41,   1, 1'b0, 1'b1, 64'h0,                   8'd1, 8'd0, 3,    1'b0};
        tv[5] = '{1'b0, 64'h4241, 2, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 8'd1, 8'd0, 1026, 1'b0};
        tv[6] = '{1'b1, 64'h42,   1, 1'b0, 1'b1, 64'h4000_0000_0000_0400, 8'd1, 8'd0, 1026, 1'b0};
        tv[7] = '{1'b0, 64'h42,   1, 1'b1, 1'b0, 64'h4000_0000_0000_0400, 8'd1, 8'd0, 1026, 1'b0};
        tv[8] = '{1'b1, 64'h4241, 2, 1'b0, 1'b1, 64'h4000_0000_0000_0000, 8'd1, 8'd0, 1026, 1'b0};
        tv[9] = '{1'b1, 64'h99,   1, 1'b0, 1'b1, 64'h0,                   8'd1, 8'd0, 3,    1'b1};

        do_reset();
        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tv[i].typ, tv[i].b, tv[i].n, tv[i].e_in, tv[i].e_out,
                   tv[i].e_ent, tv[i].e_agg, tv[i].e_drop, tv[i].e_hold, tv[i].junk);

        // Fill the table, overflow by one, then drive the drop counter into saturation.
        do_reset();
        n_in = 0;
        for (int i = 0; i < 17; i++) model_run($sformatf("fill%0d", i), 1'b0, 64'(i), 1, 1'b0);
        chk("fill.in_pulses", 64'(n_in), 64'd16);
        chk("fill.drop_one", 64'(ifc.drop_count), 64'd1);
        guard = 0;
        while (m_drop < 256 && guard < 2000) begin
            b = {48'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            model_run("drop", 1'b0, b, 2, 1'b0);
            guard++;
        end
        chk("drop.saturated", 64'(ifc.drop_count), 64'hFF);

        // Reset in the middle of a name: nothing issues, table comes back empty.
        drive_byte(8'h10, 1'b0, 1'b0);
        drive_byte(8'h11, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midname.strobes", {62'b0, ifc.in_bit, ifc.out_bit}, 64'd0);
        chk("midname.ready_in_reset", 64'(ifc.name_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midname.ready_after", 64'(ifc.name_ready), 64'd1);
        chk("midname.strobes_after", {62'b0, ifc.in_bit, ifc.out_bit}, 64'd0);
        mreset();
        run_op("midname.realloc", 1'b0, 64'h41, 1, 1'b1, 1'b0, 64'h4000_0000_0000_0000,
               8'd0, 8'd0, 1026, 1'b0);
        mv[0] = 1'b1; mt[0] = 16'hFFBE; m_entry = 64'h4000_0000_0000_0000;

        // Reset during HOLD: window abandoned, slots cleared.
        drive_byte(8'h77, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("midhold.in_bit", 64'(ifc.in_bit), 64'd1);
        repeat (10) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midhold.ready", 64'(ifc.name_ready), 64'd1);
        chk("midhold.entry", ifc.table_entry, 64'd0);
        mreset();
        model_run("midhold.data77", 1'b1, 64'h77, 1, 1'b0);
        model_run("midhold.data41", 1'b1, 64'h41, 1, 1'b0);

        // Randomized traffic over a small alphabet so hits and aggregation are common.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            b = {48'b0, 8'(8'h30 + $urandom_range(0, 3)), 8'(8'h30 + $urandom_range(0, 3))};
            model_run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), b,
                      int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pit_lookup.md
PIT_LOOKUP -- requirements
Module: pit_lookup

Interface
REQ-001 Parameters: TABLE_DEPTH, default 16, number of PIT entry slots.
REQ-002 Parameters: REGION_SIZE, default 1024, bytes of PIT memory per slot.
REQ-003 Parameters: ADDR_BASE, default 0, 62-bit base address of slot 0.
REQ-004 Parameters: HOLD_CYCLES, default 1026, busy window after a memory-moving issue.
REQ-005 Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- name_valid  in  1  name byte present.
- name_byte  in  8  name byte.
- name_last  in  1  final byte of name.
- name_type  in  1  0 = interest, 1 = data; sampled on first byte.
- name_ready  out  1  block accepts bytes.
- table_entry  out  64  [63]=0, [62]=hit/alloc flag, [61:0]=slot address.
- in_bit  out  1  one-cycle strobe: store interest at table_entry address.
- out_bit  out  1  one-cycle strobe: data lookup result valid.
- drop_count  out  8  saturating count of interests dropped, table full.
- agg_count  out  8  saturating count of aggregated duplicate interests.

Function
REQ-006 SHALL accept a byte only when name_valid and name_ready are both 1; bytes offered while name_ready=0 are ignored.
REQ-007 SHALL hash each name into a 16-bit tag: h=16'hFFFF before the first byte, h={h[14:0],h[15]} ^ {8'h00,byte} per accepted byte.
REQ-008 SHALL implement states IDLE, HASH, LOOKUP, ISSUE, HOLD.
- IDLE->HASH on first accepted byte.
- HASH->LOOKUP on name_last; a single-byte name goes IDLE->LOOKUP.
REQ-009 SHALL, in LOOKUP, compare the tag against all valid slots in one cycle.
- hit index = lowest matching slot.
- free index = lowest invalid slot.
REQ-010 SHALL present table_entry and the strobe in ISSUE, two cycles after the name_last byte is accepted.
- table_entry SHALL be registered and held until the next issue.
REQ-011 Slot address SHALL be ADDR_BASE + index*REGION_SIZE, truncated to 62 bits.
REQ-012 Interest, miss, free slot: mark slot valid with the tag, set [62]=1, pulse in_bit, enter HOLD for HOLD_CYCLES.
REQ-013 Interest, hit: no strobe, agg_count+1, return to IDLE.
REQ-014 Interest, miss, table full: no strobe, drop_count+1, return to IDLE.
REQ-015 Data, hit: set [62]=1 with the hit address, pulse out_bit, invalidate the slot in the same cycle, enter HOLD for HOLD_CYCLES.
REQ-016 Data, miss: set [62]=0 and [61:0]=0, pulse out_bit, enter HOLD for 3 cycles (downstream FIB forward path).
REQ-017 name_ready SHALL be 1 only in IDLE and HASH.
REQ-018 in_bit and out_bit SHALL never both be 1 and SHALL be high for exactly one cycle per issue.
REQ-019 Counters SHALL saturate at 8'hFF.

Reset
REQ-020 SHALL clear, on reset: all slot valid bits, table_entry=0, in_bit=0, out_bit=0, drop_count=0, agg_count=0, hold counter=0, state=IDLE.
REQ-021 name_ready SHALL be 0 while reset is high and 1 on the first cycle after reset is released.
REQ-022 Reset mid-name or mid-HOLD SHALL abandon the operation with no strobe.

Structure
REQ-023 A shared package ndn_pkg SHALL hold:
- the state enum;
- HIT_BIT=62;
- the REGION_SIZE, TABLE_DEPTH and HOLD_CYCLES defaults;
- the table_entry field layout.
REQ-024 The hash SHALL be a sub-module name_hash: byte in, first/valid in, 16-bit tag out.

Verification
REQ-025 After reset, single-byte interest 0x41 (tag 16'hFFBE) -> in_bit at cycle +2, table_entry=64'h4000_0000_0000_0000, name_ready low for 1026 cycles.
REQ-026 The same interest repeated -> no strobe, agg_count=1; a second distinct interest gets slot 1 -> table_entry[61:0]=1024.
REQ-027 Data name 0x41 -> out_bit, [62]=1, address 0; a repeated data 0x41 -> out_bit, [62]=0, 3-cycle hold.
REQ-028 17 distinct interests -> 16 in_bit pulses, then drop_count=1; after 255 further drops, drop_count stays 8'hFF.
REQ-029 Bytes presented during HOLD -> ignored, hash unaffected.
REQ-030 Reset asserted mid-name -> no strobe, all slots empty, name_ready=1 the next cycle.
